// File: rtl/padding_window_scan_if.sv
// Bundle for the padded-row input handshake and the 3x3x3 window output handshake.
// slave is the scanner's view; master is the row source / window consumer side.
interface padding_window_scan_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 416
);
    localparam int PAD_W    = OUT_W + 2;
    localparam int ROW_BITS = PAD_W * PIX_W;
    localparam int WIN_BITS = 9 * PIX_W;
    localparam int COL_W    = $clog2(OUT_W);

    logic                row_valid;
    logic                row_ready;
    logic [ROW_BITS-1:0] R_row0, G_row0, B_row0;
    logic [ROW_BITS-1:0] R_row1, G_row1, B_row1;
    logic [ROW_BITS-1:0] R_row2, G_row2, B_row2;

    logic                win_valid;
    logic                win_ready;
    logic [WIN_BITS-1:0] R_win, G_win, B_win;
    logic [COL_W-1:0]    win_col;
    logic                win_last;
    logic                frame_done;

    modport slave (
        input  row_valid,
        input  R_row0, G_row0, B_row0,
        input  R_row1, G_row1, B_row1,
        input  R_row2, G_row2, B_row2,
        output row_ready,
        output win_valid,
        input  win_ready,
        output R_win, G_win, B_win,
        output win_col,
        output win_last,
        output frame_done
    );

    modport master (
        output row_valid,
        output R_row0, G_row0, B_row0,
        output R_row1, G_row1, B_row1,
        output R_row2, G_row2, B_row2,
        input  row_ready,
        input  win_valid,
        output win_ready,
        input  R_win, G_win, B_win,
        input  win_col,
        input  win_last,
        input  frame_done
    );
endinterface

// File: rtl/padding_window_scan.sv
// Captures one band of three padded RGB rows, then streams its OUT_W 3x3x3 windows
// one per accepted transfer, counting bands to flag the end of a frame.
module padding_window_scan #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 416,
    parameter int OUT_H = 416
) (
    input  logic                  clk,
    input  logic                  rst,
    padding_window_scan_if.slave  bus
);
    localparam int PAD_W    = OUT_W + 2;
    localparam int ROW_BITS = PAD_W * PIX_W;
    localparam int WIN_BITS = 9 * PIX_W;
    localparam int COL_W    = $clog2(OUT_W);
    localparam int BAND_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(OUT_H - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t              state, state_next;
    logic [COL_W-1:0]    col;
    logic [BAND_W-1:0]   band_cnt;
    logic                frame_done_q;

    logic [ROW_BITS-1:0] cap_r [3];
    logic [ROW_BITS-1:0] cap_g [3];
    logic [ROW_BITS-1:0] cap_b [3];

    logic                row_ready_c;
    logic                win_valid_c;
    logic                capture;
    logic                advance;
    logic                col_last;
    logic                band_last;

    logic [WIN_BITS-1:0] r_win, g_win, b_win;

    assign col_last  = (col == COL_LAST);
    assign band_last = (band_cnt == BAND_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        row_ready_c = 1'b0;
        win_valid_c = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        case (state)
            ST_IDLE: begin
                row_ready_c = 1'b1;
                if (bus.row_valid) begin
                    capture    = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                win_valid_c = 1'b1;
                if (bus.win_ready) begin
                    advance = 1'b1;
                    if (col_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Column / band bookkeeping; frame_done is registered so it lands the cycle after the final transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            band_cnt     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (capture) begin
                col <= '0;
            end else if (advance) begin
                if (col_last) begin
                    col          <= '0;
                    band_cnt     <= band_last ? '0 : band_cnt + 1'b1;
                    frame_done_q <= band_last;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Row capture: cleared on reset so windows read zero until the first band arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                cap_r[r] <= '0;
                cap_g[r] <= '0;
                cap_b[r] <= '0;
            end
        end else if (capture) begin
            cap_r[0] <= bus.R_row0;
            cap_r[1] <= bus.R_row1;
            cap_r[2] <= bus.R_row2;
            cap_g[0] <= bus.G_row0;
            cap_g[1] <= bus.G_row1;
            cap_g[2] <= bus.G_row2;
            cap_b[0] <= bus.B_row0;
            cap_b[1] <= bus.B_row1;
            cap_b[2] <= bus.B_row2;
        end
    end

    // Window element r*3+c is pixel col+c of captured row r; driven only from registers.
    always_comb begin
        r_win = '0;
        g_win = '0;
        b_win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                r_win[(r*3 + c)*PIX_W +: PIX_W] = cap_r[r][(int'(col) + c)*PIX_W +: PIX_W];
                g_win[(r*3 + c)*PIX_W +: PIX_W] = cap_g[r][(int'(col) + c)*PIX_W +: PIX_W];
                b_win[(r*3 + c)*PIX_W +: PIX_W] = cap_b[r][(int'(col) + c)*PIX_W +: PIX_W];
            end
        end
    end

    assign bus.row_ready  = row_ready_c;
    assign bus.win_valid  = win_valid_c;
    assign bus.R_win      = r_win;
    assign bus.G_win      = g_win;
    assign bus.B_win      = b_win;
    assign bus.win_col    = col;
    assign bus.win_last   = (state == ST_SCAN) && col_last;
    assign bus.frame_done = frame_done_q;

    a_handshake_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(win_valid_c && row_ready_c));
    a_frame_done_idle: assert property (@(posedge clk) disable iff (rst)
        frame_done_q |-> (state == ST_IDLE));
endmodule

// File: tb/tb_padding_window_scan.sv
// Scoreboard bench for padding_window_scan: stimulus pushes expected windows, a negedge
// monitor pops and compares on every accepted transfer.
module tb_padding_window_scan;
    localparam int PIX_W    = 8;
    localparam int OUT_W    = 416;
    localparam int OUT_H    = 4;
    localparam int PAD_W    = OUT_W + 2;
    localparam int ROW_BITS = PAD_W * PIX_W;
    localparam int WIN_BITS = 9 * PIX_W;
    localparam int COL_W    = $clog2(OUT_W);

    logic clk = 1'b0;
    logic rst;
    int   checks    = 0;
    int   errors    = 0;
    int   fd_pulses = 0;

    typedef struct {
        logic [COL_W-1:0]    col;
        logic [WIN_BITS-1:0] r;
        logic [WIN_BITS-1:0] g;
        logic [WIN_BITS-1:0] b;
        logic                last;
    } exp_t;

    exp_t sb[$];

    padding_window_scan_if #(.PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();

    padding_window_scan #(.PIX_W(PIX_W), .OUT_W(OUT_W), .OUT_H(OUT_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] pix(int ch, int row, int idx, int seed);
        return PIX_W'((seed + ch*16 + row*64 + idx) % 256);
    endfunction

    function automatic logic [ROW_BITS-1:0] row_of(int ch, int row, int seed);
        logic [ROW_BITS-1:0] v;
        for (int k = 0; k < PAD_W; k++) v[k*PIX_W +: PIX_W] = pix(ch, row, k, seed);
        return v;
    endfunction

    function automatic logic [WIN_BITS-1:0] win_of(int ch, int col, int seed);
        logic [WIN_BITS-1:0] w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3 + c)*PIX_W +: PIX_W] = pix(ch, r, col + c, seed);
        return w;
    endfunction

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic drive_rows(input int seed);
        bus.R_row0 = row_of(0, 0, seed);
        bus.R_row1 = row_of(0, 1, seed);
        bus.R_row2 = row_of(0, 2, seed);
        bus.G_row0 = row_of(1, 0, seed);
        bus.G_row1 = row_of(1, 1, seed);
        bus.G_row2 = row_of(1, 2, seed);
        bus.B_row0 = row_of(2, 0, seed);
        bus.B_row1 = row_of(2, 1, seed);
        bus.B_row2 = row_of(2, 2, seed);
    endtask

    // Returns in the cycle after the capture edge.
    task automatic send_band(input int seed);
        int   n = 0;
        exp_t e;
        drive_rows(seed);
        bus.row_valid = 1'b1;
        while (!bus.row_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.row_ready) begin
            fail_timeout("capture");
            bus.row_valid = 1'b0;
            return;
        end
        for (int c = 0; c < OUT_W; c++) begin
            e.col  = COL_W'(c);
            e.r    = win_of(0, c, seed);
            e.g    = win_of(1, c, seed);
            e.b    = win_of(2, c, seed);
            e.last = (c == OUT_W - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.row_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.row_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.row_ready) fail_timeout("band_end");
    endtask

    task automatic wait_col(input int target);
        int n = 0;
        while (!(bus.win_valid && int'(bus.win_col) == target) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(bus.win_valid && int'(bus.win_col) == target)) fail_timeout("wait_col");
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_row_ready"},  128'(bus.row_ready),  128'(1));
        check_val({tag, "_win_valid"},  128'(bus.win_valid),  128'(0));
        check_val({tag, "_R_win"},      128'(bus.R_win),      128'(0));
        check_val({tag, "_G_win"},      128'(bus.G_win),      128'(0));
        check_val({tag, "_B_win"},      128'(bus.B_win),      128'(0));
        check_val({tag, "_frame_done"}, 128'(bus.frame_done), 128'(0));
        check_val({tag, "_win_col"},    128'(bus.win_col),    128'(0));
        check_val({tag, "_win_last"},   128'(bus.win_last),   128'(0));
    endtask

    // Monitor
    initial begin
        exp_t e;
        int   exp_band  = 0;
        logic pend_last = 1'b0;
        logic pend_fd   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_band  = 0;
                pend_last = 1'b0;
                pend_fd   = 1'b0;
            end else begin
                if (bus.frame_done) fd_pulses++;
                if (pend_last) begin
                    check_val("post_last_row_ready",  128'(bus.row_ready),  128'(1));
                    check_val("post_last_win_valid",  128'(bus.win_valid),  128'(0));
                    check_val("post_last_win_last",   128'(bus.win_last),   128'(0));
                    check_val("post_last_frame_done", 128'(bus.frame_done), 128'(pend_fd));
                end else if (bus.frame_done) begin
                    check_val("spurious_frame_done", 128'(bus.frame_done), 128'(0));
                end
                pend_last = 1'b0;
                pend_fd   = 1'b0;
                if (bus.win_valid && bus.win_ready) begin
                    if (sb.size() == 0) begin
                        check_val("unexpected_window", 128'(bus.win_valid), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        check_val("win_col",  128'(bus.win_col),  128'(e.col));
                        check_val("R_win",    128'(bus.R_win),    128'(e.r));
                        check_val("G_win",    128'(bus.G_win),    128'(e.g));
                        check_val("B_win",    128'(bus.B_win),    128'(e.b));
                        check_val("win_last", 128'(bus.win_last), 128'(e.last));
                        if (e.last) begin
                            pend_last = 1'b1;
                            pend_fd   = (exp_band == OUT_H - 1);
                            exp_band  = pend_fd ? 0 : exp_band + 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst           = 1'b1;
        bus.row_valid = 1'b0;
        bus.win_ready = 1'b0;
        drive_rows(99);
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("idle_row_ready", 128'(bus.row_ready), 128'(1));
        check_val("idle_win_valid", 128'(bus.win_valid), 128'(0));

        // Single band, ready held high
        bus.win_ready = 1'b1;
        send_band(0);
        check_val("first_win_valid", 128'(bus.win_valid), 128'(1));
        check_val("first_win_col",   128'(bus.win_col),   128'(0));
        cnt = 0;
        while (!bus.row_ready && cnt < 2000) begin
            if (bus.win_col == COL_W'(5))
                check_val("col5_R_e4", 128'(bus.R_win[4*PIX_W +: PIX_W]), 128'(70));
            @(posedge clk); #1;
            cnt++;
        end
        check_val("band_cycles", 128'(cnt), 128'(OUT_W));

        // Backpressure at col 100
        send_band(3);
        wait_col(100);
        bus.win_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("bp_win_col",   128'(bus.win_col),   128'(100));
            check_val("bp_win_valid", 128'(bus.win_valid), 128'(1));
            check_val("bp_R_win",     128'(bus.R_win),     128'(win_of(0, 100, 3)));
            check_val("bp_row_ready", 128'(bus.row_ready), 128'(0));
        end
        bus.win_ready = 1'b1;
        wait_idle();

        // Row inputs and row_valid ignored mid-scan
        send_band(7);
        wait_col(50);
        drive_rows(200);
        bus.row_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_val("scan_row_ready", 128'(bus.row_ready), 128'(0));
            @(posedge clk); #1;
        end
        bus.row_valid = 1'b0;
        check_val("scan_row_ready_after", 128'(bus.row_ready), 128'(0));
        wait_idle();

        // Final band of the frame, then a wrapped band
        send_band(11);
        wait_idle();
        @(posedge clk); #1;
        check_val("frame_pulses", 128'(fd_pulses), 128'(1));
        send_band(13);
        wait_idle();
        @(posedge clk); #1;
        check_val("wrap_pulses", 128'(fd_pulses), 128'(1));

        // Reset mid-scan at col 200
        send_band(17);
        wait_col(200);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check_idle_zero("midrst");
        rst = 1'b0;
        for (int b = 0; b < OUT_H; b++) begin
            send_band(21 + b);
            wait_idle();
            @(posedge clk); #1;
            check_val("post_rst_pulses", 128'(fd_pulses), 128'((b == OUT_H - 1) ? 2 : 1));
        end

        check_val("sb_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/padding_window_scan.md
# padding_window_scan

Consumer side of the padding stage. It accepts one set of three padded rows per handshake: R/G/B, rows 0..2, each PAD_W = OUT_W+2 pixels. It then streams the OUT_W 3×3×3 windows of that row band, one per accepted transfer, to the convolution engine. It also counts row bands so the engine knows where a frame ends.

## Interface
Parameters:
- PIX_W, 8, bits per pixel
- OUT_W, 416, windows per row band (unpadded row width)
- OUT_H, 416, row bands per frame

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- row_valid  in  1  padded row band present on inputs
- row_ready  out  1  block can capture a row band
- R_row0/G_row0/B_row0  in  (OUT_W+2)*PIX_W  top padded row per channel
- R_row1/G_row1/B_row1  in  (OUT_W+2)*PIX_W  middle padded row
- R_row2/G_row2/B_row2  in  (OUT_W+2)*PIX_W  bottom padded row
- win_valid  out  1  window outputs valid
- win_ready  in  1  downstream accepts window
- R_win/G_win/B_win  out  9*PIX_W  3×3 window per channel
- win_col  out  $clog2(OUT_W)  column index of current window
- win_last  out  1  current window is column OUT_W-1
- frame_done  out  1  one-cycle pulse after last window of band OUT_H-1

## Operation
- Pixel k of a row occupies bits [k*PIX_W +: PIX_W]; pixel 0 is the left pad.
- Window element e = r*3+c (r = row 0..2, c = 0..2) occupies bits [e*PIX_W +: PIX_W] and equals row r, pixel col+c.
- FSM has two states:
  - IDLE: row_ready=1, win_valid=0. On row_valid&&row_ready, capture all nine rows into internal registers, set col←0, and go to SCAN.
  - SCAN: row_ready=0, win_valid=1. Row inputs and row_valid are ignored. On win_valid&&win_ready:
    - if col<OUT_W-1, col←col+1
    - else go to IDLE and advance band_cnt.
  - With win_ready=0, col and all outputs hold.
- Window outputs are a mux of the captured registers indexed by col. There is no combinational path from row inputs or win_ready to any output.
- win_col = col. win_last = (state==SCAN && col==OUT_W-1).
- band_cnt counts 0..OUT_H-1. On the final transfer of band OUT_H-1, band_cnt←0 and frame_done pulses for exactly the next cycle. Otherwise frame_done=0.

## Timing
- Reset, applied at any time including mid-scan, sets the following on the next edge:
  - state IDLE, col 0, band_cnt 0, frame_done 0, win_valid 0, row_ready 1
  - captured rows all zero, so R_win/G_win/B_win = 0 and win_last 0.
- Capture at edge N gives win_valid=1 with col 0 from cycle N+1.
- With win_ready held high, col 0..OUT_W-1 occupy OUT_W consecutive cycles.
- After the last transfer, row_ready=1 in the following cycle. That is one bubble per band, so a band takes OUT_W+1 cycles minimum from capture to next capture.
- Last transfer at edge M: state IDLE and frame_done=1 (if the final band) during cycle M+1.
- A row_valid held through SCAN is not captured until IDLE; the row source must hold rows stable while row_valid=1 && row_ready=0.
- win_ready toggling is legal every cycle; only cycles where both valid and ready are high advance col.

## Test plan
- Reset then idle: after rst, check row_ready=1, win_valid=0, all window bits 0, frame_done=0, win_col=0.
- Single band, win_ready=1: rows with pixel value = (row*64 + index) mod 256.
  - Expect 416 consecutive windows.
  - Window col 5 R_win element 4 = pixel 6 of row1 = 70.
  - win_last only at col 415.
  - row_ready returns exactly one cycle after the last transfer.
- Backpressure: drop win_ready for 3 cycles at col 100. Expect col, window and win_valid to hold, then resume at 100 with no skip or duplicate.
- Ignore during scan: change row inputs and pulse row_valid mid-SCAN. Expect windows still from the captured data, and row_ready=0 throughout.
- Frame boundary: run OUT_H bands. frame_done pulses exactly once, one cycle after the last window of band 415. band_cnt wraps and the next band gives no extra pulse.
- Reset mid-scan: assert rst at col 200. The next cycle must show IDLE outputs and zeroed windows, and a new capture must restart at col 0 with band_cnt 0.
